// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial accelerator MMIO front end.
package fact_pkg;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DONE_BIT = 0;
    localparam int ERR_BIT  = 1;
    localparam int TO_BIT   = 2;

    localparam int RES_W = 32;

endpackage

// File: rtl/fact_mmio_if_if.sv
// SoC bus signals of the factorial MMIO block; the bus master drives, the block responds.
interface fact_bus_if;

    logic                       we;
    logic [1:0]                 a;
    logic [fact_pkg::RES_W-1:0] wd;
    logic [fact_pkg::RES_W-1:0] rd;

    modport master (output we, a, wd, input rd);
    modport slave  (input we, a, wd, output rd);

endinterface

// File: rtl/fact_timeout_cnt.sv
// Run watchdog: counts cycles while enabled and flags the last allowed cycle.
module fact_timeout_cnt #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == LAST);

    // Hold at the terminal count so a stale enable cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fact_mmio_if.sv
// Register front end for the factorial core: operand/start writes, go pulse,
// bounded wait for done/error, sticky status and result capture.
//
// state | meaning
// IDLE  | no run in progress, N writable, GO accepted
// START | go_out high for this single cycle
// WAIT  | waiting for done_in/error_in or the timeout
module fact_mmio_if
    import fact_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    fact_bus_if.slave        bus,
    output logic [3:0]       n_out,
    output logic             go_out,
    input  logic             done_in,
    input  logic             error_in,
    input  logic [RES_W-1:0] result_in
);

    state_t           state;
    logic [3:0]       n_reg;
    logic [RES_W-1:0] result_reg;
    logic             done_f;
    logic             err_f;
    logic             to_f;

    logic n_wr;
    logic go_wr;
    logic busy;
    logic cnt_clr;
    logic cnt_en;
    logic to_expired;
    logic unused_wd;

    assign n_wr    = bus.we && (bus.a == ADDR_N);
    assign go_wr   = bus.we && (bus.a == ADDR_GO) && bus.wd[0];
    assign busy    = (state != IDLE);
    assign cnt_clr = (state == IDLE) && go_wr;
    assign cnt_en  = (state == WAIT);
    assign n_out   = n_reg;

    assign unused_wd = ^bus.wd[RES_W-1:4];

    fact_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n_reg      <= '0;
            result_reg <= '0;
            done_f     <= 1'b0;
            err_f      <= 1'b0;
            to_f       <= 1'b0;
            go_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (n_wr) begin
                        n_reg <= bus.wd[3:0];
                    end
                    if (go_wr) begin
                        state  <= START;
                        go_out <= 1'b1;
                        done_f <= 1'b0;
                        err_f  <= 1'b0;
                        to_f   <= 1'b0;
                    end
                end
                START: begin
                    go_out <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // Error wins over a same-cycle done so a bad operand never yields a result.
                    if (error_in) begin
                        err_f      <= 1'b1;
                        result_reg <= '0;
                        state      <= IDLE;
                    end else if (done_in) begin
                        done_f     <= 1'b1;
                        result_reg <= result_in;
                        state      <= IDLE;
                    end else if (to_expired) begin
                        to_f  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    go_out <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.a)
            ADDR_N:      bus.rd[3:0] = n_reg;
            ADDR_GO:     bus.rd[0]   = busy;
            ADDR_STATUS: begin
                bus.rd[DONE_BIT] = done_f;
                bus.rd[ERR_BIT]  = err_f;
                bus.rd[TO_BIT]   = to_f;
            end
            ADDR_RESULT: bus.rd = result_reg;
            default:     bus.rd = '0;
        endcase
    end

endmodule
